// File: rtl/row_window_pkg.sv
// rtl/row_window_pkg.sv - shared state encodings, counter width and sum sizing for row_window
package row_window_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_VALID = 2'd1;
    localparam state_t ST_STALL = 2'd2;

    localparam int COUNT_W = 16;

    // Width of an unsigned sum of win_rows words that cannot overflow.
    function automatic int sum_width(input int width, input int win_rows);
        return width + $clog2(win_rows);
    endfunction

endpackage

// File: rtl/window_col_sum.sv
// rtl/window_col_sum.sv - unsigned sum of one window column across all WIN_ROWS rows
module window_col_sum
    import row_window_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int WIN_ROWS = 3,
    parameter int SUM_W    = sum_width(WIDTH, WIN_ROWS)
) (
    input  logic [WIN_ROWS-1:0][WIDTH-1:0] col,
    output logic [SUM_W-1:0]               sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIN_ROWS; i++) begin
            sum = sum + SUM_W'(col[i]);
        end
    end

endmodule

// File: rtl/row_window.sv
// rtl/row_window.sv - sliding WIN_ROWS-row window over FIFO rows; ROW_WINDOW_SUM_EN adds per-column win_sum
module row_window
    import row_window_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ROW_SIZE = 3,
    parameter int WIN_ROWS = 3
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [ROW_SIZE-1:0][WIDTH-1:0]               fifo_data,
    input  logic                                         fifo_empty,
    output logic                                         fifo_re,
    input  logic                                         flush,
    output logic [WIN_ROWS-1:0][ROW_SIZE-1:0][WIDTH-1:0] win_data,
    output logic                                         win_valid,
    input  logic                                         win_ready,
`ifdef ROW_WINDOW_SUM_EN
    output logic [ROW_SIZE-1:0][sum_width(WIDTH, WIN_ROWS)-1:0] win_sum,
`endif
    output logic [COUNT_W-1:0]                           win_count
);

    localparam int FILL_W = $clog2(WIN_ROWS + 1);

    typedef logic [ROW_SIZE-1:0][WIDTH-1:0] row_t;
    typedef row_t [WIN_ROWS-1:0]            window_t;

    state_t              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    window_t             win_q, win_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                pop;
    logic                hs;

    always_comb begin
        pop = !fifo_empty && !flush &&
              (state_q == ST_FILL || state_q == ST_STALL ||
               (state_q == ST_VALID && win_ready));
        hs  = (state_q == ST_VALID) && win_ready && !flush;

        state_d = state_q;
        fill_d  = fill_q;
        win_d   = win_q;
        count_d = count_q;

        if (flush) begin
            state_d = ST_FILL;
            fill_d  = '0;
            win_d   = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < WIN_ROWS - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[WIN_ROWS-1] = fifo_data;
            end
            if (hs) begin
                count_d = count_q + 1'b1;
            end
            case (state_q)
                ST_FILL: begin
                    if (pop) begin
                        fill_d = fill_q + 1'b1;
                        if (fill_q == FILL_W'(WIN_ROWS - 1)) begin
                            state_d = ST_VALID;
                        end
                    end
                end
                // Handshake without a replacement row leaves nothing to present.
                ST_VALID: begin
                    if (win_ready && !pop) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (pop) begin
                        state_d = ST_VALID;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            win_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            win_q   <= win_d;
            count_q <= count_d;
        end
    end

    assign fifo_re   = pop;
    assign win_valid = (state_q == ST_VALID);
    assign win_data  = win_q;
    assign win_count = count_q;

`ifdef ROW_WINDOW_SUM_EN
    for (genvar c = 0; c < ROW_SIZE; c++) begin : g_col
        logic [WIN_ROWS-1:0][WIDTH-1:0] col;
        for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
            assign col[r] = win_q[r][c];
        end
        window_col_sum #(
            .WIDTH    (WIDTH),
            .WIN_ROWS (WIN_ROWS)
        ) u_col_sum (
            .col (col),
            .sum (win_sum[c])
        );
    end
`endif

endmodule

// File: tb/tb_row_window.sv
// tb/tb_row_window.sv - scoreboard testbench for row_window
module tb_row_window;

    localparam int WIDTH    = 32;
    localparam int ROW_SIZE = 3;
    localparam int WIN_ROWS = 3;

    typedef logic [ROW_SIZE-1:0][WIDTH-1:0] row_t;
    typedef row_t [WIN_ROWS-1:0]            window_t;

    logic        clock;
    logic        reset;
    row_t        fifo_data;
    logic        fifo_empty;
    logic        fifo_re;
    logic        flush;
    window_t     win_data;
    logic        win_valid;
    logic        win_ready;
    logic [15:0] win_count;
`ifdef ROW_WINDOW_SUM_EN
    logic [ROW_SIZE-1:0][WIDTH+$clog2(WIN_ROWS)-1:0] win_sum;
`endif

    row_window #(
        .WIDTH    (WIDTH),
        .ROW_SIZE (ROW_SIZE),
        .WIN_ROWS (WIN_ROWS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .flush      (flush),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
`ifdef ROW_WINDOW_SUM_EN
        .win_sum    (win_sum),
`endif
        .win_count  (win_count)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          pop_cnt = 0;
    logic [15:0] model_cnt = '0;
    row_t        fifo_q[$];
    row_t        hist[$];
    window_t     exp_q[$];

    function automatic row_t mk_row(input int a, input int b, input int c);
        row_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        return r;
    endfunction

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic clear_model();
        fifo_q.delete();
        hist.delete();
        exp_q.delete();
        model_cnt = '0;
        refresh();
    endtask

    task automatic push_row(input row_t r);
        window_t w;
        fifo_q.push_back(r);
        hist.push_back(r);
        if (hist.size() > WIN_ROWS) void'(hist.pop_front());
        if (hist.size() == WIN_ROWS) begin
            for (int i = 0; i < WIN_ROWS; i++) w[i] = hist[i];
            exp_q.push_back(w);
        end
        refresh();
    endtask

    // One clock: observe at negedge, let the edge happen, then update the FIFO model.
    task automatic tick();
        logic    do_pop;
        logic    do_flush;
        window_t exp_w;
        @(negedge clock);
        do_pop   = fifo_re;
        do_flush = flush;
        if (win_valid && win_ready && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_window: handshake with no expected window, got %h", win_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (win_data !== exp_w) begin
                    bad++;
                    $display("FAIL sb_window: got %h want %h", win_data, exp_w);
                end
            end
            total++;
            if (win_count !== model_cnt) begin
                bad++;
                $display("FAIL sb_count: got %0d want %0d", win_count, model_cnt);
            end
            model_cnt = model_cnt + 1'b1;
        end
        @(posedge clock);
        #1;
        if (do_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        if (do_flush) clear_model();
        refresh();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total++;
        if (win_valid !== 1'b0 || win_count !== 16'd0 || win_data !== '0) begin
            bad++;
            $display("FAIL flush_state: got valid=%b count=%0d data=%h want 0/0/0", win_valid, win_count, win_data);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_count !== 16'd0 || fifo_re !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: got valid=%b data=%h count=%0d re=%b want zeros", win_valid, win_data, win_count, fifo_re);
        end
        reset = 1'b0;
        push_row(mk_row(9, 9, 9));
        #1;
        total++;
        if (fifo_re !== 1'b1) begin
            bad++;
            $display("FAIL reset_re_follows: got %b want 1", fifo_re);
        end
        clear_model();
        #1;
        total++;
        if (fifo_re !== 1'b0) begin
            bad++;
            $display("FAIL reset_re_empty: got %b want 0", fifo_re);
        end
    endtask

    task automatic test_basic();
        do_flush();
        win_ready = 1'b1;
        pop_cnt = 0;
        push_row(mk_row(1, 2, 3));
        push_row(mk_row(4, 5, 6));
        push_row(mk_row(7, 8, 9));
        tick();
        tick();
        total++;
        if (win_valid !== 1'b0 || pop_cnt != 2) begin
            bad++;
            $display("FAIL basic_fill: got valid=%b pops=%0d want 0/2", win_valid, pop_cnt);
        end
        tick();
        total++;
        if (win_valid !== 1'b1 || pop_cnt != 3) begin
            bad++;
            $display("FAIL basic_latency: got valid=%b pops=%0d want 1/3", win_valid, pop_cnt);
        end
`ifdef ROW_WINDOW_SUM_EN
        total++;
        if (win_sum[0] !== 34'd12 || win_sum[1] !== 34'd15 || win_sum[2] !== 34'd18) begin
            bad++;
            $display("FAIL basic_sum: got %0d,%0d,%0d want 12,15,18", win_sum[0], win_sum[1], win_sum[2]);
        end
`endif
        tick();
        total++;
        if (win_valid !== 1'b0 || win_count !== 16'd1 || pop_cnt != 3) begin
            bad++;
            $display("FAIL basic_done: got valid=%b count=%0d pops=%0d want 0/1/3", win_valid, win_count, pop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        win_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_row(mk_row(10*i, 10*i+1, 10*i+2));
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (win_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_valid[%0d]: got %b want 1", k, win_valid);
            end
        end
        tick();
        total++;
        if (win_valid !== 1'b0 || win_count !== 16'd4) begin
            bad++;
            $display("FAIL b2b_end: got valid=%b count=%0d want 0/4", win_valid, win_count);
        end
    endtask

    task automatic test_hold();
        window_t held;
        do_flush();
        win_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_row(mk_row(i+100, i+200, i+300));
        repeat (3) tick();
        held = win_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (fifo_re !== 1'b0 || win_data !== held || win_count !== 16'd0 || win_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold[%0d]: got re=%b count=%0d valid=%b data=%h want 0/0/1 %h", k, fifo_re, win_count, win_valid, win_data, held);
            end
        end
        win_ready = 1'b1;
        #1;
        total++;
        if (fifo_re !== 1'b1) begin
            bad++;
            $display("FAIL hold_release_re: got %b want 1", fifo_re);
        end
        tick();
        total++;
        if (win_count !== 16'd1 || win_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got count=%0d valid=%b want 1/1", win_count, win_valid);
        end
        tick();
        total++;
        if (win_count !== 16'd2 || win_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_to_stall: got count=%0d valid=%b want 2/0", win_count, win_valid);
        end
    endtask

    task automatic test_stall();
        row_t r;
        r = mk_row(77, 78, 79);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (win_valid !== 1'b0 || fifo_re !== 1'b0) begin
                bad++;
                $display("FAIL stall_idle[%0d]: got valid=%b re=%b want 0/0", k, win_valid, fifo_re);
            end
        end
        push_row(r);
        #1;
        total++;
        if (fifo_re !== 1'b1) begin
            bad++;
            $display("FAIL stall_pop: got %b want 1", fifo_re);
        end
        tick();
        total++;
        if (win_valid !== 1'b1 || win_data[2] !== r) begin
            bad++;
            $display("FAIL stall_resume: got valid=%b row2=%h want 1 %h", win_valid, win_data[2], r);
        end
        tick();
    endtask

    task automatic test_flush();
        do_flush();
        win_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_row(mk_row(i+50, i+60, i+70));
        repeat (4) tick();
        total++;
        if (win_count !== 16'd1 || win_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre: got count=%0d valid=%b want 1/1", win_count, win_valid);
        end
        flush = 1'b1;
        #1;
        total++;
        if (fifo_re !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_pop: got %b want 0", fifo_re);
        end
        tick();
        flush = 1'b0;
        total++;
        if (win_count !== 16'd0 || win_valid !== 1'b0 || win_data !== '0) begin
            bad++;
            $display("FAIL flush_hs: got count=%0d valid=%b data=%h want 0/0/0", win_count, win_valid, win_data);
        end
        pop_cnt = 0;
        for (int i = 0; i < 3; i++) push_row(mk_row(i+1000, i+2000, i+3000));
        repeat (2) tick();
        total++;
        if (win_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_refill_early: got %b want 0", win_valid);
        end
        tick();
        total++;
        if (win_valid !== 1'b1 || pop_cnt != 3) begin
            bad++;
            $display("FAIL flush_refill: got valid=%b pops=%0d want 1/3", win_valid, pop_cnt);
        end
        tick();
    endtask

    task automatic test_wrap();
        int n;
        int guard;
        do_flush();
        win_ready  = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = mk_row(5, 6, 7);
        n = 0;
        guard = 0;
        while (n < 65536 && guard < 70000) begin
            @(negedge clock);
            guard++;
            if (win_valid && win_ready) n++;
            @(posedge clock);
            #1;
            if (n == 65535) begin
                total++;
                if (win_count !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL wrap_max: got %h want ffff", win_count);
                end
            end
        end
        win_ready = 1'b0;
        refresh();
        total++;
        if (n != 65536) begin
            bad++;
            $display("FAIL wrap_timeout: got %0d handshakes want 65536", n);
        end
        total++;
        if (win_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero: got %h want 0000", win_count);
        end
    endtask

    task automatic test_reset_mid();
        do_flush();
        win_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_row(mk_row(i+40, i+41, i+42));
        repeat (2) tick();
        total++;
        if (win_data[2] !== mk_row(41, 42, 43)) begin
            bad++;
            $display("FAIL mid_fill: got %h want %h", win_data[2], mk_row(41, 42, 43));
        end
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        total++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_count !== 16'd0 || fifo_re !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got valid=%b data=%h count=%0d re=%b want zeros", win_valid, win_data, win_count, fifo_re);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push_row(mk_row(i+7, i+8, i+9));
        repeat (2) tick();
        total++;
        if (win_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_refill_early: got %b want 0", win_valid);
        end
        tick();
        total++;
        if (win_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_refill: got %b want 1", win_valid);
        end
    endtask

    initial begin
        clock      = 1'b0;
        reset      = 1'b1;
        flush      = 1'b0;
        win_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
